// File: rtl/shift_seq_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
// State encodings and default datapath sizes.
package shift_seq_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_AMT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_l1_stage.sv
// Single shift-left-by-one stage.
// The extra top bit carries the bit pushed out of the MSB.
module shift_l1_stage #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH:0]   dout
);

  assign dout = {din, 1'b0};

endmodule

// File: rtl/shift_seq_ctrl.sv
// Iterative left-shift sequencer with start/busy/done handshake.
// One bit per clock through a single shift stage.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH:0]   sh;

  shift_l1_stage #(
    .WIDTH (WIDTH)
  ) u_sh (
    .din  (work),
    .dout (sh)
  );

  assign result = work;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      work  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            work  <= data_in;
            cnt   <= amount;
            carry <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt == '0) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            work  <= sh[WIDTH-1:0];
            carry <= sh[WIDTH];
            ovf   <= ovf | sh[WIDTH];
            cnt   <= cnt - AMT_W'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomized self-checking bench for shift_seq_ctrl.
// Reference model works on whole-operation arithmetic and a cycle timer.
module tb_shift_seq_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        start;
  logic [15:0] data_in;
  logic [3:0]  amount;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        ovf;

  shift_seq_ctrl dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .start   (start),
    .data_in (data_in),
    .amount  (amount),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .carry   (carry),
    .ovf     (ovf)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;
  int ndone = 0;
  logic [15:0] er = '0;
  logic ec = 1'b0;
  logic eo = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Whole-operation result: shift in 32 bits, top half holds spilled bits
  task automatic predict(input logic [15:0] d, input logic [3:0] a);
    logic [31:0] full;
    full = {16'h0, d} << a;
    er = full[15:0];
    ec = (a != 4'd0) ? full[16] : 1'b0;
    eo = |full[31:16];
  endtask

  task automatic cycle(input logic r, input logic s,
                       input logic [15:0] d, input logic [3:0] a);
    Reset   = r;
    start   = s;
    data_in = d;
    amount  = a;
    @(posedge CLK);
    if (!r) begin
      t  = 0;
      er = '0;
      ec = 1'b0;
      eo = 1'b0;
    end else if (t == 0 && s) begin
      predict(d, a);
      t = int'(a) + 2;
    end else if (t > 0) begin
      t--;
    end
    #1;
    check("busy", 32'(busy), 32'(t > 0));
    check("done", 32'(done), 32'(t == 1));
    if (done) ndone++;
    if (t <= 1) begin
      check("result", 32'(result), 32'(er));
      check("carry", 32'(carry), 32'(ec));
      check("ovf", 32'(ovf), 32'(eo));
    end
  endtask

  task automatic op(input string tag, input logic [15:0] d,
                    input logic [3:0] a, input logic [15:0] xr,
                    input logic xc, input logic xo);
    int k;
    bit seen;
    seen = 0;
    cycle(1'b1, 1'b1, d, a);
    for (k = 1; k <= 20 && !seen; k++) begin
      cycle(1'b1, 1'b0, 16'($urandom), 4'($urandom));
      if (done) begin
        seen = 1;
        check({tag, "_lat"}, 32'(k), 32'(int'(a) + 1));
        check({tag, "_res"}, 32'(result), 32'(xr));
        check({tag, "_cy"}, 32'(carry), 32'(xc));
        check({tag, "_ov"}, 32'(ovf), 32'(xo));
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'(0), 32'(1));
    cycle(1'b1, 1'b0, 16'h0, 4'h0);
  endtask

  initial begin
    int d0;
    Reset   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    amount  = '0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'hFFFF, 4'hF);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_res", 32'(result), 32'(0));

    op("t1", 16'h0001, 4'd4, 16'h0010, 1'b0, 1'b0);
    op("t2", 16'hFFFF, 4'd15, 16'h8000, 1'b1, 1'b1);
    op("t3", 16'hABCD, 4'd0, 16'hABCD, 1'b0, 1'b0);

    // start re-pulsed while busy must be ignored
    d0 = ndone;
    cycle(1'b1, 1'b1, 16'h8001, 4'd1);
    cycle(1'b1, 1'b1, 16'h1234, 4'd3);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'h0, 4'd0);
    check("t4_res", 32'(result), 32'(16'h0002));
    check("t4_cy", 32'(carry), 32'(1));
    check("t4_ov", 32'(ovf), 32'(1));
    check("t4_ndone", 32'(ndone - d0), 32'(1));

    // reset mid-operation aborts with no done pulse
    d0 = ndone;
    cycle(1'b1, 1'b1, 16'h00FF, 4'd10);
    cycle(1'b1, 1'b0, 16'h0, 4'd0);
    cycle(1'b1, 1'b0, 16'h0, 4'd0);
    cycle(1'b0, 1'b0, 16'h0, 4'd0);
    check("t5_busy", 32'(busy), 32'(0));
    check("t5_res", 32'(result), 32'(0));
    check("t5_cy", 32'(carry), 32'(0));
    check("t5_ov", 32'(ovf), 32'(0));
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 16'h0, 4'd0);
    check("t5_ndone", 32'(ndone - d0), 32'(0));

    // start held high: back-to-back operations every n+3 edges
    d0 = ndone;
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, 16'h0003, 4'd2);
    check("t6_ndone", 32'(ndone - d0), 32'(3));
    check("t6_res", 32'(result), 32'(16'h000C));
    cycle(1'b0, 1'b0, 16'h0, 4'd0);

    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 39) != 0),
            1'($urandom_range(0, 2) == 0),
            16'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
